trigger_info_arbiter: RTL

Round-robin arbiter that merges trigger-information words from NUM_SRC trigger receivers (front-panel pulse, TTC, internal) into the single Pulse Trigger FIFO write port. It sits between the receivers' FIFO-side valid/ready outputs and the FIFO. It tags each word with its source index and keeps per-source accepted-word counters and a FIFO-stall flag for status readback.

---
 rtl/trigger_info_arbiter_pkg.sv | 52 +++++
 rtl/trigger_info_arbiter_if.sv | 45 ++++
 rtl/trigger_info_arbiter_rr_priority_select.sv | 44 ++++
 rtl/trigger_info_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/trigger_info_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_info_arbiter_pkg
//  Description : Shared constants, FSM encoding and word helpers for the
//                trigger-information path (arbiter, readout scheduler).
//                Trigger word layout (128 bits):
//                  [127:124] source tag
//                  [69:68]   trig_length
//                  [67:44]   trig_num
//                  [43:0]    trig_timestamp
//  Revision    : 1.0 - initial release
// ============================================================================
package trigger_info_arbiter_pkg;

    localparam int C_TRIG_WORD_W    = 128;

    localparam int C_TAG_MSB        = 127;
    localparam int C_TAG_LSB        = 124;
    localparam int C_TAG_W          = C_TAG_MSB - C_TAG_LSB + 1;

    localparam int C_TRIG_LENGTH_MSB = 69;
    localparam int C_TRIG_LENGTH_LSB = 68;
    localparam int C_TRIG_NUM_MSB    = 67;
    localparam int C_TRIG_NUM_LSB    = 44;
    localparam int C_TRIG_TS_MSB     = 43;
    localparam int C_TRIG_TS_LSB     = 0;

    // Bit positions inside the one-hot state readback
    localparam int C_STATE_IDLE_BIT = 0;
    localparam int C_STATE_SEND_BIT = 1;

    localparam int C_GRANT_W        = 3;
    localparam int C_CNT_W          = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_SEND = 2'b10
    } arb_state_e;

    // Replace the tag field of a trigger word with a source index.
    function automatic logic [C_TRIG_WORD_W-1:0] tag_word(
        input logic [C_TRIG_WORD_W-1:0] word,
        input logic [C_TAG_W-1:0]       tag
    );
        logic [C_TRIG_WORD_W-1:0] w_out;
        w_out                       = word;
        w_out[C_TAG_MSB:C_TAG_LSB]  = tag;
        return w_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_info_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_info_arbiter_if
//  Description : Bundles the receiver-side and FIFO-side valid/ready
//                handshakes of the trigger-info arbiter.
//                  src_valid/src_data/src_ready : NUM_SRC receiver ports,
//                                                 source i at [128*i +: 128]
//                  fifo_valid/fifo_data/fifo_ready : Pulse Trigger FIFO port
//                Modport slave  : the arbiter side
//                Modport master : the receivers + FIFO environment side
//  Revision    : 1.0 - initial release
// ============================================================================
interface trigger_info_arbiter_if
    import trigger_info_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 2
) ();

    logic [NUM_SRC-1:0]               src_valid;
    logic [C_TRIG_WORD_W*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]               src_ready;
    logic                             fifo_valid;
    logic [C_TRIG_WORD_W-1:0]         fifo_data;
    logic                             fifo_ready;

    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready,
        output fifo_valid,
        output fifo_data,
        input  fifo_ready
    );

    modport master (
        output src_valid,
        output src_data,
        input  src_ready,
        input  fifo_valid,
        input  fifo_data,
        output fifo_ready
    );

endinterface
`default_nettype wire

// File: rtl/trigger_info_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_select
//  Description : Combinational round-robin pick. Searches the request vector
//                starting one above the last grant, wrapping modulo N, and
//                returns the first requester as one-hot and as an index.
//  Ports       : i_req     - request vector
//                i_last    - index of the previous grant
//                o_onehot  - one-hot selection (zero when no request)
//                o_idx     - selected index (zero when no request)
//                o_any     - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
    parameter int N     = 2,
    parameter int IDX_W = 3
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_last,
    output logic      [N-1:0]     o_onehot,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_any
);

    always_comb begin
        int cand;
        cand     = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        // Offset N lands back on i_last itself, so the last winner is
        // only chosen again when nobody else is requesting.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(i_last) + k) % N;
            if (!o_any && i_req[cand]) begin
                o_any          = 1'b1;
                o_onehot[cand] = 1'b1;
                o_idx          = IDX_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trigger_info_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_info_arbiter
//  Description : Round-robin merge of NUM_SRC trigger-info receivers into the
//                Pulse Trigger FIFO write port. Each word is optionally tagged
//                with its source index; per-source accepted-word counters and
//                a sticky FIFO-stall flag are kept for status readback.
//  Ports       : clk          - 40 MHz TTC clock
//                reset_n      - asynchronous active-low reset
//                enable       - permit new grants (in-flight word completes)
//                bus          - receiver and FIFO handshakes (slave modport)
//                reset_counts - synchronous clear of counters and stall_error
//                grant        - index of last/current granted source
//                accept_cnt   - 24-bit counter per source, i at [24*i +: 24]
//                stall_error  - sticky: a word waited STALL_LIMIT cycles
//                state        - one-hot FSM state {SEND, IDLE}
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_info_arbiter
    import trigger_info_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int TAG_EN      = 1,
    parameter int STALL_LIMIT = 1024
) (
    input  wire logic                         clk,
    input  wire logic                         reset_n,
    input  wire logic                         enable,
    trigger_info_arbiter_if.slave             bus,
    input  wire logic                         reset_counts,
    output logic      [C_GRANT_W-1:0]         grant,
    output logic      [C_CNT_W*NUM_SRC-1:0]   accept_cnt,
    output logic                              stall_error,
    output logic      [1:0]                   state
);

    localparam int                C_STALL_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [C_STALL_W-1:0] C_STALL_LIMIT = C_STALL_W'(STALL_LIMIT);

    arb_state_e                     r_state;
    arb_state_e                     w_state_next;
    logic                           r_fifo_valid;
    logic [C_TRIG_WORD_W-1:0]       r_fifo_data;
    logic [C_GRANT_W-1:0]           r_grant;
    logic [C_CNT_W*NUM_SRC-1:0]     r_accept_cnt;
    logic [C_STALL_W-1:0]           r_stall_cnt;
    logic                           r_stall_error;

    logic [NUM_SRC-1:0]             w_sel_onehot;
    logic [C_GRANT_W-1:0]           w_sel_idx;
    logic                           w_sel_any;
    logic                           w_grant_go;
    logic                           w_fifo_xfer;
    logic                           w_stalled;
    logic [C_TRIG_WORD_W-1:0]       w_sel_word;

    rr_priority_select #(
        .N     (NUM_SRC),
        .IDX_W (C_GRANT_W)
    ) u_rr_select (
        .i_req    (bus.src_valid),
        .i_last   (r_grant),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_sel_idx),
        .o_any    (w_sel_any)
    );

    // ------------------------------------------------------------------
    // Next-state / handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant_go   = 1'b0;
        w_fifo_xfer  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // reset_n gates the grant so src_ready stays low while the
                // block is held in reset, even with valid requests present.
                if (reset_n && enable && w_sel_any) begin
                    w_grant_go   = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.fifo_ready) begin
                    w_fifo_xfer  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_stalled = (r_state == ST_SEND) && !bus.fifo_ready;

    // Word mux from the one-hot selection, then optional source tagging.
    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_sel_onehot[i]) begin
                w_sel_word = bus.src_data[i*C_TRIG_WORD_W +: C_TRIG_WORD_W];
            end
        end
        if (TAG_EN != 0) begin
            w_sel_word = tag_word(w_sel_word, C_TAG_W'(w_sel_idx));
        end
    end

    // ------------------------------------------------------------------
    // State, output word and grant registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_fifo_valid <= 1'b0;
            r_fifo_data  <= '0;
            r_grant      <= C_GRANT_W'(NUM_SRC - 1);
        end else begin
            r_state <= w_state_next;
            if (w_grant_go) begin
                r_fifo_valid <= 1'b1;
                r_fifo_data  <= w_sel_word;
                r_grant      <= w_sel_idx;
            end else if (w_fifo_xfer) begin
                r_fifo_valid <= 1'b0;
                r_fifo_data  <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-source accepted-word counters (wrap at 24 bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_accept_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (reset_counts) begin
                    r_accept_cnt[i*C_CNT_W +: C_CNT_W] <= '0;
                end else if (w_grant_go && w_sel_onehot[i]) begin
                    r_accept_cnt[i*C_CNT_W +: C_CNT_W] <=
                        r_accept_cnt[i*C_CNT_W +: C_CNT_W] + C_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO stall watchdog. The counter saturates at the limit so a very
    // long stall cannot wrap it; the flag sets on the cycle the count
    // reaches the limit and only reset_counts clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt   <= '0;
            r_stall_error <= 1'b0;
        end else begin
            if (w_grant_go) begin
                r_stall_cnt <= '0;
            end else if (w_stalled && (r_stall_cnt != C_STALL_LIMIT)) begin
                r_stall_cnt <= r_stall_cnt + C_STALL_W'(1);
            end

            if (reset_counts) begin
                r_stall_error <= 1'b0;
            end else if (w_stalled && (r_stall_cnt == C_STALL_LIMIT - C_STALL_W'(1))) begin
                r_stall_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.src_ready  = w_grant_go ? w_sel_onehot : '0;
    assign bus.fifo_valid = r_fifo_valid;
    assign bus.fifo_data  = r_fifo_data;
    assign grant          = r_grant;
    assign accept_cnt     = r_accept_cnt;
    assign stall_error    = r_stall_error;
    assign state          = r_state;

endmodule
`default_nettype wire
